clkmux_switch_ctrl: RTL and testbench

CLKMUX_SWITCH_CTRL -- requirements
Module: clkmux_switch_ctrl

---
 rtl/clkmux_switch_ctrl.sv | 151 +++++++++++++++
 tb/tb_clkmux_switch_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkmux_switch_ctrl.sv
// Clock-source switch controller for a glitch-free clock mux.
// Sequences a source change as: ask downstream logic to quiesce, wait for
// its acknowledge (bounded by a timeout), flip the mux select, hold it for a
// settle interval, then release the quiesce request and wait for downstream
// to drop its acknowledge before reporting completion.
module clkmux_switch_ctrl #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_req,
  input  logic sw_sel,
  input  logic quiesce_ack,
  output logic cur_sel,
  output logic quiesce_req,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SWITCH,
    ST_RELEASE
  } state_t;

  // Terminal counter values; the counter starts at 0 on each state entry,
  // so reaching N-1 on an edge means N edges have been spent in the state.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             target_q, target_d;
  logic             cur_sel_q, cur_sel_d;
  logic             qreq_q, qreq_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // Next-state and next-output decode; done/err default low so they pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    cur_sel_d = cur_sel_q;
    qreq_d    = qreq_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sw_req) begin
          if (sw_sel == cur_sel_q) begin
            // Already on the requested source: complete without a handshake.
            done_d = 1'b1;
          end else begin
            target_d = sw_sel;
            cnt_d    = '0;
            state_d  = ST_REQ;
            qreq_d   = 1'b1;
            busy_d   = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // Acknowledge wins over a timeout landing on the same edge.
        if (quiesce_ack) begin
          state_d   = ST_SWITCH;
          cur_sel_d = target_q;
          cnt_d     = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          qreq_d  = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_SWITCH: begin
        // quiesce_ack is deliberately not looked at while settling.
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          qreq_d  = 1'b0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_RELEASE: begin
        // No timeout here: downstream must eventually drop its acknowledge.
        if (!quiesce_ack) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        qreq_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset takes effect without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      target_q  <= 1'b0;
      cur_sel_q <= 1'b0;
      qreq_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      cur_sel_q <= cur_sel_d;
      qreq_q    <= qreq_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cur_sel     = cur_sel_q;
  assign quiesce_req = qreq_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_clkmux_switch_ctrl.sv
// Self-checking bench for clkmux_switch_ctrl: a vector table for the basic
// switch / no-op flows, directed sequences for timeout, ack-on-timeout,
// ignored requests and asynchronous reset, and a randomized run checked
// against an event-level reference model.
module tb_clkmux_switch_ctrl;
  localparam int S  = 8;
  localparam int TO = 255;
  localparam int CW = 8;
  localparam int N  = 3000;
  localparam int NV = 19;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw_req = 1'b0;
  logic sw_sel = 1'b0;
  logic quiesce_ack = 1'b0;
  logic cur_sel, quiesce_req, busy, done, err;
  logic [4:0] obs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clkmux_switch_ctrl #(
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_req     (sw_req),
    .sw_sel     (sw_sel),
    .quiesce_ack(quiesce_ack),
    .cur_sel    (cur_sel),
    .quiesce_req(quiesce_req),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Output bundle order: {cur_sel, quiesce_req, busy, done, err}
  assign obs = {cur_sel, quiesce_req, busy, done, err};

  typedef struct packed {
    logic       r;
    logic       rq;
    logic       sl;
    logic       ak;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [NV];

  logic       req_a [N];
  logic       sel_a [N];
  logic       ack_a [N];
  logic [4:0] e_a   [N];

  task automatic chk5(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: {cur,qreq,busy,done,err} got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic step(input logic r, input logic rq, input logic sl, input logic ak);
    @(negedge clk);
    reset = r;
    sw_req = rq;
    sw_sel = sl;
    quiesce_ack = ak;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic rq, input logic sl,
                              input logic ak, input logic [4:0] exp);
    vec_t v;
    v.r = r; v.rq = rq; v.sl = sl; v.ak = ak; v.exp = exp;
    return v;
  endfunction

  task automatic set_e(input int t, input logic c, input logic q, input logic b,
                       input logic d, input logic er);
    e_a[t] = {c, q, b, d, er};
  endtask

  // Event-level model: index t is the value seen after rising edge t.
  // A request accepted at edge t waits for the first ack within edges
  // t+1..t+TO; an ack at edge a flips the select, the quiesce request is held
  // through edge a+S-1, and completion comes at the first later edge with
  // ack low. With no ack, err fires at edge t+TO.
  task automatic build_model();
    int   t;
    int   k;
    logic cur;
    logic tgt;
    bit   found;
    bit   released;
    cur = 1'b0;
    t = 0;
    while (t < N) begin
      set_e(t, cur, 1'b0, 1'b0, 1'b0, 1'b0);
      if (req_a[t] && (sel_a[t] == cur)) begin
        set_e(t, cur, 1'b0, 1'b0, 1'b1, 1'b0);
        t++;
      end else if (req_a[t]) begin
        tgt = sel_a[t];
        set_e(t, cur, 1'b1, 1'b1, 1'b0, 1'b0);
        t++;
        k = 0;
        found = 1'b0;
        while (t < N && !found && k < TO) begin
          k++;
          if (ack_a[t]) begin
            found = 1'b1;
            cur = tgt;
            set_e(t, cur, 1'b1, 1'b1, 1'b0, 1'b0);
          end else if (k == TO) begin
            set_e(t, cur, 1'b0, 1'b0, 1'b0, 1'b1);
          end else begin
            set_e(t, cur, 1'b1, 1'b1, 1'b0, 1'b0);
          end
          t++;
        end
        if (found) begin
          for (int j = 1; j <= S && t < N; j++) begin
            set_e(t, cur, (j < S), 1'b1, 1'b0, 1'b0);
            t++;
          end
          released = 1'b0;
          while (t < N && !released) begin
            if (!ack_a[t]) begin
              released = 1'b1;
              set_e(t, cur, 1'b0, 1'b0, 1'b1, 1'b0);
            end else begin
              set_e(t, cur, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            t++;
          end
        end
      end else begin
        t++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   first_err;
    int   done_cnt;
    int   err_cnt;
    int   busy_cnt;
    logic [4:0] at_to;
    int   seg;
    logic av;

    // Full switch with ack tied high, release, then no-op requests.
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 5'b01100);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'b11100);
    for (int i = 3; i <= 9; i++) tbl[i] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'b11100);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'b10100);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'b10100);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'b10010);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'b10000);
    tbl[14] = mk(1'b0, 1'b1, 1'b1, 1'b0, 5'b10010);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'b10000);
    tbl[16] = mk(1'b0, 1'b1, 1'b1, 1'b0, 5'b10010);
    tbl[17] = mk(1'b0, 1'b1, 1'b1, 1'b0, 5'b10010);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'b10000);

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].r, tbl[i].rq, tbl[i].sl, tbl[i].ak);
      chk5($sformatf("vec[%0d]", i), obs, tbl[i].exp);
    end

    // Timeout with ack held low.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk5("to_reset", obs, 5'b00000);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk5("to_accept", obs, 5'b01100);
    first_err = 0; done_cnt = 0; busy_cnt = 0; at_to = '0;
    for (int k = 1; k <= TO; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (err && first_err == 0) first_err = k;
      if (done) done_cnt++;
      if (k < TO && busy && quiesce_req) busy_cnt++;
      if (k == TO) at_to = obs;
    end
    chki("to_err_edge", first_err, TO);
    chki("to_busy_cycles", busy_cnt, TO - 1);
    chk5("to_at_timeout", at_to, 5'b00001);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    if (done) done_cnt++;
    chk5("to_after", obs, 5'b00000);
    chki("to_no_done", done_cnt, 0);

    // Ack arriving on the exact timeout edge.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk5("tie_accept", obs, 5'b01100);
    err_cnt = 0;
    for (int k = 1; k < TO; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (err) err_cnt++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk5("tie_ack_wins", obs, 5'b11100);
    chki("tie_no_err", err_cnt, 0);

    // Requests and ack dropouts during SWITCH and RELEASE are ignored.
    done_cnt = 0;
    for (int j = 1; j <= S; j++) begin
      step(1'b0, logic'(j % 2), 1'b0, logic'(j % 3 != 0));
      if (done) done_cnt++;
      chk5($sformatf("ign_switch[%0d]", j), obs, (j < S) ? 5'b11100 : 5'b10100);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    if (done) done_cnt++;
    chk5("ign_release_done", obs, 5'b10010);
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (done) done_cnt++;
    end
    chk5("ign_idle", obs, 5'b10000);
    chki("ign_one_done", done_cnt, 1);

    // Asynchronous reset in the middle of SWITCH.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk5("ar_in_switch", obs, 5'b11100);
    #2;
    reset = 1'b1;
    #1;
    chk5("ar_async_clear", obs, 5'b00000);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk5("ar_held", obs, 5'b00000);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk5("ar_first_edge_accept", obs, 5'b01100);

    // Randomized run against the event-level model.
    seg = 0;
    av = 1'b1;
    for (int t = 0; t < N; t++) begin
      if (seg == 0) begin
        av = ~av;
        seg = av ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 350));
      end
      ack_a[t] = av;
      seg--;
      req_a[t] = ($urandom_range(0, 5) == 0);
      sel_a[t] = logic'($urandom_range(0, 1));
    end
    build_model();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk5("rand_reset", obs, 5'b00000);
    for (int t = 0; t < N; t++) begin
      step(1'b0, req_a[t], sel_a[t], ack_a[t]);
      chk5($sformatf("rand[%0d]", t), obs, e_a[t]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
